bram_stream_reader: RTL and testbench

Read-side sequencer for the simple dual-port BRAM in the AGC datapath. On a start command it issues `ren`/`radd` to the BRAM read port for a contiguous, wrapping address range. It absorbs the one-cycle BRAM read latency and presents the words as a valid/ready stream with backpressure. It sits between the BRAM read port and downstream AGC consumers, such as gain-table lookup and coefficient playback.

---
 rtl/bram_stream_reader_if.sv | 36 +++
 rtl/bram_stream_reader.sv | 144 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM read-port and output-stream signals of the BRAM stream reader.
// The slave modport is the reader's view; the master modport is its environment.
// N_ADDR and DATA_WIDTH must match the reader instance they connect to.
interface bram_stream_reader_if #(
  parameter int N_ADDR     = 256,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N_ADDR);

  // Command side
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [AW:0]           len;
  logic                  busy;
  logic                  done;

  // BRAM read port
  logic                  ren;
  logic [AW-1:0]         radd;
  logic [DATA_WIDTH-1:0] rdata;

  // Output stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport slave (
    input  start, base_addr, len, rdata, m_ready,
    output busy, done, ren, radd, m_data, m_valid
  );

  modport master (
    output start, base_addr, len, rdata, m_ready,
    input  busy, done, ren, radd, m_data, m_valid
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Purpose: reads a contiguous, wrapping BRAM address range and streams the words out.
// Latency: start sampled at E0 -> ren in cycle 1 -> first m_valid in cycle 3.
// Backpressure: reads are credit-limited so the 4-entry FIFO can never overflow.
module bram_stream_reader #(
  parameter int N_ADDR     = 256,
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_stream_reader_if.slave bus
);
  localparam int AW         = $clog2(N_ADDR);
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic [AW:0]           issue_cnt_q;
  logic [AW:0]           accept_cnt_q;
  logic                  pend_q;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            fifo_cnt_q;

  logic                  load;
  logic                  ren;
  logic                  push;
  logic                  pop;
  logic                  fifo_vld;
  logic [2:0]            occupancy;
  logic                  credit_ok;

  // A read issued now lands in the FIFO two edges later; counting the word
  // sitting in the capture stage as occupied keeps the FIFO at <= 4 entries.
  assign occupancy = fifo_cnt_q + {2'b00, pend_q};
  assign credit_ok = (occupancy < 3'(FIFO_DEPTH));
  assign fifo_vld  = (fifo_cnt_q != 3'd0);
  assign push      = pend_q;
  assign pop       = fifo_vld & bus.m_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM next-state, read issue and command acceptance
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    ren     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            load    = 1'b1;
            state_d = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        ren = credit_ok;
        if (credit_ok && (issue_cnt_q == (AW+1)'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (accept_cnt_q == (AW+1)'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, issue/accept counters and the capture-stage pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      pend_q       <= 1'b0;
    end else begin
      pend_q <= ren;
      if (load) begin
        addr_q       <= bus.base_addr;
        issue_cnt_q  <= bus.len;
        accept_cnt_q <= bus.len;
      end else begin
        if (ren) begin
          addr_q      <= addr_q + AW'(1);
          issue_cnt_q <= issue_cnt_q - (AW+1)'(1);
        end
        if (pop) begin
          accept_cnt_q <= accept_cnt_q - (AW+1)'(1);
        end
      end
    end
  end

  // Output FIFO: rdata captured on the pending cycle, head popped on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= bus.rdata;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      fifo_cnt_q <= fifo_cnt_q + 3'(push) - 3'(pop);
    end
  end

  assign bus.ren     = ren;
  assign bus.radd    = addr_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.m_valid = fifo_vld;
  assign bus.m_data  = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural one-cycle-latency BRAM
// preloaded with mem[i] = i; every expectation below is hand-derived.
module tb_bram_stream_reader;
  localparam int N_ADDR = 256;
  localparam int DW     = 16;

  logic clk = 1'b0;
  logic rst_n;

  bram_stream_reader_if #(.N_ADDR(N_ADDR), .DATA_WIDTH(DW)) bus ();

  bram_stream_reader #(.N_ADDR(N_ADDR), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: data valid one cycle after ren is sampled
  logic [DW-1:0] mem [N_ADDR];
  always @(posedge clk) begin
    if (bus.ren) bus.rdata <= mem[bus.radd];
  end

  // Passive monitors (only ever written here)
  int ren_cnt  = 0;
  int done_cnt = 0;
  int got_q[$];
  int radd_q[$];
  always @(posedge clk) begin
    if (bus.ren) begin
      ren_cnt <= ren_cnt + 1;
      radd_q.push_back(int'(bus.radd));
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.m_valid && bus.m_ready) got_q.push_back(int'(bus.m_data));
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns in cycle 1 of that command
  task automatic issue(input int base, input int n);
    bus.start     = 1'b1;
    bus.base_addr = 8'(base);
    bus.len       = 9'(n);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  int n, b, rb, dc, seen, stall_err, order_err, hold_v;
  logic [DW-1:0] hold_d;
  int exp_w[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N_ADDR; i++) mem[i] = DW'(i);
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.m_ready   = 1'b0;
    #1;
    chk("rst_busy",   32'(bus.busy),    0);
    chk("rst_done",   32'(bus.done),    0);
    chk("rst_ren",    32'(bus.ren),     0);
    chk("rst_radd",   32'(bus.radd),    0);
    chk("rst_mvalid", 32'(bus.m_valid), 0);
    chk("rst_mdata",  32'(bus.m_data),  0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: base 10, len 5, always ready -> data cycles 3..7, done cycle 8
    bus.m_ready = 1'b1;
    rb = ren_cnt;
    issue(10, 5);
    chk("t1_ren_c1",    32'(bus.ren),     1);
    chk("t1_radd_c1",   32'(bus.radd),    10);
    chk("t1_busy_c1",   32'(bus.busy),    1);
    chk("t1_mvalid_c1", 32'(bus.m_valid), 0);
    step();
    chk("t1_mvalid_c2", 32'(bus.m_valid), 0);
    for (int c = 3; c <= 7; c++) begin
      step();
      chk("t1_mvalid", 32'(bus.m_valid), 1);
      chk("t1_mdata",  32'(bus.m_data),  32'(10 + c - 3));
      chk("t1_nodone", 32'(bus.done),    0);
    end
    step();
    chk("t1_done_c8",   32'(bus.done),    1);
    chk("t1_busy_c8",   32'(bus.busy),    0);
    chk("t1_mvalid_c8", 32'(bus.m_valid), 0);
    step();
    chk("t1_done_pulse", 32'(bus.done), 0);
    chk("t1_ren_count",  32'(ren_cnt - rb), 5);

    // 2: address wrap 254,255,0,1
    exp_w = '{254, 255, 0, 1};
    b  = got_q.size();
    rb = radd_q.size();
    issue(254, 4);
    wait_done("t2_done", 50, n);
    chk("t2_done_cycle", 32'(n), 6);
    chk("t2_radd_n", 32'(radd_q.size() - rb), 4);
    chk("t2_word_n", 32'(got_q.size() - b), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_radd", 32'(radd_q[rb + i]), 32'(exp_w[i]));
      chk("t2_data", 32'(got_q[b + i]),   32'(exp_w[i]));
    end

    // 3: backpressure, 20 stalled cycles then random ready
    bus.m_ready = 1'b0;
    b  = got_q.size();
    rb = ren_cnt;
    stall_err = 0;
    hold_v = 0;
    hold_d = '0;
    issue(100, 16);
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid) begin
        if (hold_v != 0 && bus.m_data !== hold_d) stall_err++;
        hold_v = 1;
        hold_d = bus.m_data;
      end
      step();
    end
    chk("t3_stall_ren",    32'(ren_cnt - rb), 4);
    chk("t3_stall_mvalid", 32'(bus.m_valid),  1);
    chk("t3_stall_mdata",  32'(bus.m_data),   100);
    n = 0;
    seen = 0;
    while (seen == 0 && n < 400) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      hold_v = (bus.m_valid && !bus.m_ready) ? 1 : 0;
      hold_d = bus.m_data;
      step();
      n++;
      if (hold_v != 0 && (bus.m_valid !== 1'b1 || bus.m_data !== hold_d)) stall_err++;
      if (bus.done === 1'b1) seen = 1;
    end
    chk("t3_done",   32'(seen), 1);
    chk("t3_stable", 32'(stall_err), 0);
    chk("t3_word_n", 32'(got_q.size() - b), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", 32'(got_q[b + i]), 32'(100 + i));
    end

    // 4: len 0, then a start while busy is ignored
    bus.m_ready = 1'b1;
    rb = ren_cnt;
    issue(5, 0);
    chk("t4_done_c1", 32'(bus.done), 1);
    chk("t4_busy_c1", 32'(bus.busy), 0);
    chk("t4_ren_c1",  32'(bus.ren),  0);
    step();
    chk("t4_done_c2", 32'(bus.done), 0);
    chk("t4_busy_c2", 32'(bus.busy), 0);
    chk("t4_no_ren",  32'(ren_cnt - rb), 0);
    b = got_q.size();
    issue(20, 3);
    bus.start     = 1'b1;
    bus.base_addr = 8'd50;
    bus.len       = 9'd2;
    step();
    bus.start = 1'b0;
    wait_done("t4_done", 50, n);
    step(); step(); step();
    chk("t4_idle_after", 32'(bus.busy), 0);
    chk("t4_word_n", 32'(got_q.size() - b), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_data", 32'(got_q[b + i]), 32'(20 + i));
    end

    // 5: full range from base 7, back-to-back start in the done cycle
    b = got_q.size();
    issue(7, 256);
    wait_done("t5_done", 600, n);
    chk("t5_done_cycle", 32'(n), 258);
    chk("t5_word_n", 32'(got_q.size() - b), 256);
    order_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (got_q.size() <= b + i || got_q[b + i] != ((7 + i) % 256)) order_err++;
    end
    chk("t5_order", 32'(order_err), 0);
    chk("t5_busy_done", 32'(bus.busy), 0);
    b = got_q.size();
    issue(3, 1);
    chk("t5_b2b_ren",  32'(bus.ren),  1);
    chk("t5_b2b_radd", 32'(bus.radd), 3);
    chk("t5_b2b_busy", 32'(bus.busy), 1);
    wait_done("t5_b2b_done", 20, n);
    chk("t5_b2b_word_n", 32'(got_q.size() - b), 1);
    chk("t5_b2b_data",   32'(got_q[b]), 3);

    // 6: reset mid-transfer, then a fresh command
    bus.m_ready = 1'b0;
    issue(40, 8);
    step(); step(); step(); step();
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_busy",   32'(bus.busy),    0);
    chk("t6_done",   32'(bus.done),    0);
    chk("t6_ren",    32'(bus.ren),     0);
    chk("t6_radd",   32'(bus.radd),    0);
    chk("t6_mvalid", 32'(bus.m_valid), 0);
    chk("t6_mdata",  32'(bus.m_data),  0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_done", 32'(done_cnt - dc), 0);
    chk("t6_idle",    32'(bus.busy), 0);
    bus.m_ready = 1'b1;
    b = got_q.size();
    issue(60, 3);
    wait_done("t6_done2", 30, n);
    chk("t6_word_n", 32'(got_q.size() - b), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t6_data", 32'(got_q[b + i]), 32'(60 + i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
